mem_write_buffer: RTL and testbench
===================================

Name: mem_write_buffer

Overview:
- Posted-write buffer between the cache's memory-side port and external memory.
- Cache writes (write-back evictions, write-throughs) retire into a small FIFO in 1 cycle; the FIFO drains to memory in the background.
- Reads bypass buffered writes. A read whose address matches a buffered write is served from the buffer, so the cache never sees stale data.

Parameters:
- ADDR_WIDTH, 32, address width; all addresses word-aligned, compare on [ADDR_WIDTH-1:2]
- DATA_WIDTH, 32, data word width
- DEPTH, 4, buffer entries; power of two, >= 2

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- up_addr  in  ADDR_WIDTH  cache-side request address
- up_rd  in  1  cache read request; held until up_ready
- up_wr  in  1  cache write request; held until up_ready; never together with up_rd
- up_wdata  in  DATA_WIDTH  cache write data
- up_rdata  out  DATA_WIDTH  read data, valid while up_ready=1 for a read
- up_ready  out  1  one-cycle completion pulse, registered
- dn_addr  out  ADDR_WIDTH  memory address
- dn_rd  out  1  memory read request
- dn_wr  out  1  memory write request
- dn_wdata  out  DATA_WIDTH  memory write data
- dn_rdata  in  DATA_WIDTH  memory read data, valid when dn_ready=1
- dn_ready  in  1  memory completion; a transfer completes on a posedge with dn_ready=1
- empty  out  1  buffer holds no entries and no downstream write is in flight

Behaviour:
- Reset (async): all outputs 0 (empty=1), count=0, head/tail=0, FSM=IDLE. Buffered entries are discarded. A mid-transfer dn_rd/dn_wr drops immediately.
- Storage: DEPTH entries of {addr, data}; circular head/tail pointers with wrap; count 0..DEPTH.
- Upstream acceptance is blocked in any cycle where up_ready=1, so a held request is not double-counted.
- Write accept: up_wr=1 and count<DEPTH, sampled at edge N. Entry pushed at N; up_ready=1 for cycle N..N+1.
- Full: up_wr stalls with up_ready=0. Accepted on the first edge where count<DEPTH, including the edge on which a drain pop completes.
- Same-edge push and pop: count unchanged; both pointers advance.
- Read hit: up_rd=1 and any valid entry matches. Data comes from the newest matching entry. up_rdata/up_ready are registered, giving 1-cycle latency. Memory is not accessed.
- Read miss: no match. FSM IDLE->RD; dn_rd=1 and dn_addr=up_addr from the next cycle.
  - On a dn_ready edge: capture dn_rdata into up_rdata, pulse up_ready, FSM->RESP->IDLE.
  - Reads take priority over starting a drain. A drain already in progress completes first.
- Drain: in IDLE with count>0 and no read pending, FSM->WR; dn_wr=1 with dn_addr/dn_wdata = head entry.
  - On a dn_ready edge: pop head, deassert dn_wr the next cycle, FSM->IDLE.
  - At most one downstream transfer is outstanding.
- FSM states:
  - IDLE: accepts read-miss or drain starts.
  - RD: waits for dn_ready, then ->RESP.
  - RESP: drives the up_ready pulse, then ->IDLE.
  - WR: waits for dn_ready, then ->IDLE.
- Writes are accepted in every state, including RD and WR.
- dn_addr/dn_wdata are stable while dn_rd or dn_wr=1. dn_rd and dn_wr are never both 1.
- Ordering: same-address writes retire in program order. No coalescing: duplicate addresses occupy separate entries.
- empty = (count==0) && FSM!=WR.

Optional Feature:
- Macro WBUF_FWD_EN.
- Defined: read hits are forwarded from the buffer as described above.
- Undefined: no address compare logic. Every read waits until the buffer is fully drained (empty=1), then issues to memory. Read latency then includes all pending drains. up_rdata always comes from dn_rdata.

Test Plan:
- Reset/idle: rst_n low mid-WR with dn_wr=1 -> dn_wr=0 immediately; empty=1, up_ready=0 after release.
- Posted write + drain: write 0x100=0xDEADBEEF, memory ready after 3 cycles -> up_ready the cycle after the request; dn_wr with addr 0x100/data 0xDEADBEEF; empty=1 after the dn_ready edge.
- Full stall: hold dn_ready=0, issue 5 writes to 0x0,0x4,0x8,0xC,0x10 -> 4 accepted; 5th stalls with up_ready=0. Pulse dn_ready once -> 0x0 drained, 5th accepted same edge, count stays 4.
- Forwarding (WBUF_FWD_EN): buffered writes 0x20=0x11 then 0x20=0x22; read 0x20 -> up_rdata=0x22 with 1-cycle latency; no dn_rd.
- Read bypass: buffered write 0x40; read 0x80 with memory returning 0x55 -> dn_rd issued before the 0x40 drain; up_rdata=0x55; then 0x40 drains.
- No-forward build: same stimulus as the forwarding case -> both writes drained first, then dn_rd 0x20; up_rdata equals memory value 0x22.

Source files
------------

// File: rtl/mem_write_buffer.sv
// mem_write_buffer: posted-write FIFO between the cache memory-side port and
// external memory. Writes retire in one cycle and drain in the background;
// reads bypass buffered writes.
// Build option WBUF_FWD_EN: when defined, reads that hit a buffered write are
// served from the buffer (newest match). When undefined, a read waits for the
// buffer to drain fully and is always served by memory.
module mem_write_buffer #(
   parameter int unsigned ADDR_WIDTH = 32,
   parameter int unsigned DATA_WIDTH = 32,
   parameter int unsigned DEPTH      = 4
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic [ADDR_WIDTH-1:0] up_addr,
   input  logic                  up_rd,
   input  logic                  up_wr,
   input  logic [DATA_WIDTH-1:0] up_wdata,
   output logic [DATA_WIDTH-1:0] up_rdata,
   output logic                  up_ready,
   output logic [ADDR_WIDTH-1:0] dn_addr,
   output logic                  dn_rd,
   output logic                  dn_wr,
   output logic [DATA_WIDTH-1:0] dn_wdata,
   input  logic [DATA_WIDTH-1:0] dn_rdata,
   input  logic                  dn_ready,
   output logic                  empty
);

   localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int unsigned CNT_W = PTR_W + 1;

   typedef enum logic [1:0] {S_IDLE, S_RD, S_RESP, S_WR} state_e;

   state_e                state_q, state_d;
   logic [PTR_W-1:0]      head_q, head_d;
   logic [PTR_W-1:0]      tail_q, tail_d;
   logic [CNT_W-1:0]      count_q, count_d;
   logic                  up_ready_q, up_ready_d;
   logic [DATA_WIDTH-1:0] up_rdata_q, up_rdata_d;
   logic                  dn_rd_q, dn_rd_d;
   logic                  dn_wr_q, dn_wr_d;
   logic [ADDR_WIDTH-1:0] dn_addr_q, dn_addr_d;
   logic [DATA_WIDTH-1:0] dn_wdata_q, dn_wdata_d;
   logic                  empty_q, empty_d;

   logic [ADDR_WIDTH-1:0] ent_addr_q [DEPTH];
   logic [DATA_WIDTH-1:0] ent_data_q [DEPTH];

   logic                  rd_pending;
   logic                  rd_hit;
   logic                  rd_go;
   logic [DATA_WIDTH-1:0] hit_data;
   logic                  push;
   logic                  pop;

   // A request is only considered while no completion pulse is showing,
   // so a held request is never taken twice.
   assign rd_pending = up_rd & ~up_ready_q;
   assign pop        = (state_q == S_WR) & dn_ready;
   assign push       = up_wr & ~up_ready_q & ((count_q != CNT_W'(DEPTH)) | pop);

`ifdef WBUF_FWD_EN
   logic hit;

   // Scan oldest to newest so the newest matching entry wins
   always_comb begin
      hit      = 1'b0;
      hit_data = '0;
      for (int unsigned k = 0; k < DEPTH; k++) begin
         if ((CNT_W'(k) < count_q) &&
             (ent_addr_q[head_q + PTR_W'(k)][ADDR_WIDTH-1:2] == up_addr[ADDR_WIDTH-1:2])) begin
            hit      = 1'b1;
            hit_data = ent_data_q[head_q + PTR_W'(k)];
         end
      end
   end

   assign rd_hit = rd_pending & hit;
   assign rd_go  = rd_pending & ~hit;
`else
   assign hit_data = '0;
   assign rd_hit   = 1'b0;
   assign rd_go    = rd_pending & (count_q == '0);
`endif

   // Next-state: pointers, count, FSM and all registered outputs
   always_comb begin
      state_d    = state_q;
      head_d     = head_q;
      tail_d     = tail_q;
      up_ready_d = 1'b0;
      up_rdata_d = up_rdata_q;
      dn_rd_d    = dn_rd_q;
      dn_wr_d    = dn_wr_q;
      dn_addr_d  = dn_addr_q;
      dn_wdata_d = dn_wdata_q;

      if (push) tail_d = tail_q + PTR_W'(1);
      if (pop)  head_d = head_q + PTR_W'(1);
      count_d = count_q + CNT_W'(push) - CNT_W'(pop);

      if (push) up_ready_d = 1'b1;
      if (rd_hit) begin
         up_ready_d = 1'b1;
         up_rdata_d = hit_data;
      end

      case (state_q)
         S_IDLE: begin
            if (rd_go) begin
               state_d   = S_RD;
               dn_rd_d   = 1'b1;
               dn_addr_d = up_addr;
            end else if (count_q != '0) begin
               state_d    = S_WR;
               dn_wr_d    = 1'b1;
               dn_addr_d  = ent_addr_q[head_q];
               dn_wdata_d = ent_data_q[head_q];
            end
         end
         S_RD: begin
            if (dn_ready) begin
               state_d    = S_RESP;
               dn_rd_d    = 1'b0;
               up_rdata_d = dn_rdata;
               up_ready_d = 1'b1;
            end
         end
         S_RESP: state_d = S_IDLE;
         S_WR: begin
            if (dn_ready) begin
               state_d = S_IDLE;
               dn_wr_d = 1'b0;
            end
         end
         default: state_d = S_IDLE;
      endcase

      empty_d = (count_d == '0) && (state_d != S_WR);
   end

   // Control and output registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= S_IDLE;
         head_q     <= '0;
         tail_q     <= '0;
         count_q    <= '0;
         up_ready_q <= 1'b0;
         up_rdata_q <= '0;
         dn_rd_q    <= 1'b0;
         dn_wr_q    <= 1'b0;
         dn_addr_q  <= '0;
         dn_wdata_q <= '0;
         empty_q    <= 1'b1;
      end else begin
         state_q    <= state_d;
         head_q     <= head_d;
         tail_q     <= tail_d;
         count_q    <= count_d;
         up_ready_q <= up_ready_d;
         up_rdata_q <= up_rdata_d;
         dn_rd_q    <= dn_rd_d;
         dn_wr_q    <= dn_wr_d;
         dn_addr_q  <= dn_addr_d;
         dn_wdata_q <= dn_wdata_d;
         empty_q    <= empty_d;
      end
   end

   // Entry storage; contents are qualified by count, so no reset needed
   always_ff @(posedge clk) begin
      if (push) begin
         ent_addr_q[tail_q] <= up_addr;
         ent_data_q[tail_q] <= up_wdata;
      end
   end

   assign up_ready = up_ready_q;
   assign up_rdata = up_rdata_q;
   assign dn_rd    = dn_rd_q;
   assign dn_wr    = dn_wr_q;
   assign dn_addr  = dn_addr_q;
   assign dn_wdata = dn_wdata_q;
   assign empty    = empty_q;

endmodule

// File: tb/tb_mem_write_buffer.sv
// Directed self-checking bench for mem_write_buffer with a small memory
// responder (fixed latency or single manual pulses) that logs every transfer.
module tb_mem_write_buffer;
   localparam int unsigned AW = 32;
   localparam int unsigned DW = 32;

   logic          clk;
   logic          rst_n;
   logic [AW-1:0] up_addr;
   logic          up_rd;
   logic          up_wr;
   logic [DW-1:0] up_wdata;
   logic [DW-1:0] up_rdata;
   logic          up_ready;
   logic [AW-1:0] dn_addr;
   logic          dn_rd;
   logic          dn_wr;
   logic [DW-1:0] dn_wdata;
   logic [DW-1:0] dn_rdata;
   logic          dn_ready;
   logic          empty;

   int n_cmp  = 0;
   int n_fail = 0;

   // responder controls (written by tests) and state (written by responder)
   int            lat         = 1;
   bit            auto_resp   = 1'b0;
   int            pulse_cnt   = 0;
   int            pulses_done = 0;
   int            wait_cnt    = 0;
   logic [DW-1:0] rd_value    = '0;
   int            n_tx        = 0;
   bit            tx_wr   [64];
   logic [AW-1:0] tx_addr [64];
   logic [DW-1:0] tx_data [64];

   mem_write_buffer #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .DEPTH(4)) dut (
      .clk(clk), .rst_n(rst_n),
      .up_addr(up_addr), .up_rd(up_rd), .up_wr(up_wr), .up_wdata(up_wdata),
      .up_rdata(up_rdata), .up_ready(up_ready),
      .dn_addr(dn_addr), .dn_rd(dn_rd), .dn_wr(dn_wr), .dn_wdata(dn_wdata),
      .dn_rdata(dn_rdata), .dn_ready(dn_ready), .empty(empty)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // memory model: drives dn_ready mid-high-phase, logs each completed transfer
   initial begin
      dn_ready = 1'b0;
      dn_rdata = '0;
      forever begin
         @(posedge clk);
         #2;
         dn_ready = 1'b0;
         if (!rst_n || !(dn_rd || dn_wr)) begin
            wait_cnt = 0;
         end else if (auto_resp || (pulses_done != pulse_cnt)) begin
            wait_cnt++;
            if (!auto_resp || wait_cnt >= lat) begin
               dn_ready = 1'b1;
               dn_rdata = rd_value;
               if (n_tx < 64) begin
                  tx_wr[n_tx]   = dn_wr;
                  tx_addr[n_tx] = dn_addr;
                  tx_data[n_tx] = dn_wdata;
               end
               n_tx++;
               wait_cnt = 0;
               if (!auto_resp) pulses_done++;
            end
         end
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish, got timeout want completion");
      $fatal(1);
   end

   task automatic do_write(input logic [AW-1:0] a, input logic [DW-1:0] d, output int cyc);
      up_addr = a; up_wdata = d; up_wr = 1'b1; cyc = 0;
      do begin @(negedge clk); cyc++; end while (up_ready !== 1'b1 && cyc < 100);
      up_wr = 1'b0;
      @(negedge clk);
   endtask

   task automatic do_read(input logic [AW-1:0] a, output logic [DW-1:0] d, output int cyc);
      up_addr = a; up_rd = 1'b1; cyc = 0;
      do begin @(negedge clk); cyc++; end while (up_ready !== 1'b1 && cyc < 100);
      d = up_rdata;
      up_rd = 1'b0;
      @(negedge clk);
   endtask

   task automatic wait_empty(output int cyc);
      cyc = 0;
      while (!(empty === 1'b1 && dn_rd === 1'b0) && cyc < 200) begin
         @(negedge clk); cyc++;
      end
   endtask

   task automatic test_reset;
      int cyc;
      auto_resp = 1'b0;
      rst_n = 1'b0;
      repeat (2) @(negedge clk);
      n_cmp++; if (up_ready !== 1'b0) begin n_fail++; $display("FAIL rst_up_ready: got %b want 0", up_ready); end
      n_cmp++; if (empty !== 1'b1) begin n_fail++; $display("FAIL rst_empty: got %b want 1", empty); end
      n_cmp++; if (dn_wr !== 1'b0) begin n_fail++; $display("FAIL rst_dn_wr: got %b want 0", dn_wr); end
      n_cmp++; if (dn_rd !== 1'b0) begin n_fail++; $display("FAIL rst_dn_rd: got %b want 0", dn_rd); end
      rst_n = 1'b1;
      @(negedge clk);
      do_write(32'h8, 32'h5, cyc);
      n_cmp++; if (cyc != 1) begin n_fail++; $display("FAIL rst_wr_latency: got %0d want 1", cyc); end
      n_cmp++; if (dn_wr !== 1'b1) begin n_fail++; $display("FAIL rst_drain_started: got %b want 1", dn_wr); end
      #2 rst_n = 1'b0;
      #1;
      n_cmp++; if (dn_wr !== 1'b0) begin n_fail++; $display("FAIL rst_async_dn_wr: got %b want 0", dn_wr); end
      n_cmp++; if (empty !== 1'b1) begin n_fail++; $display("FAIL rst_async_empty: got %b want 1", empty); end
      @(negedge clk);
      rst_n = 1'b1;
      repeat (2) @(negedge clk);
      n_cmp++; if (dn_wr !== 1'b0) begin n_fail++; $display("FAIL rst_discard_dn_wr: got %b want 0", dn_wr); end
      n_cmp++; if (empty !== 1'b1) begin n_fail++; $display("FAIL rst_discard_empty: got %b want 1", empty); end
      n_cmp++; if (up_ready !== 1'b0) begin n_fail++; $display("FAIL rst_release_up_ready: got %b want 0", up_ready); end
   endtask

   task automatic test_posted_write;
      int cyc;
      int base;
      auto_resp = 1'b1; lat = 3; base = n_tx;
      do_write(32'h100, 32'hDEADBEEF, cyc);
      n_cmp++; if (cyc != 1) begin n_fail++; $display("FAIL pw_latency: got %0d want 1", cyc); end
      n_cmp++; if (dn_wr !== 1'b1) begin n_fail++; $display("FAIL pw_dn_wr: got %b want 1", dn_wr); end
      n_cmp++; if (dn_addr !== 32'h100) begin n_fail++; $display("FAIL pw_dn_addr: got %h want 00000100", dn_addr); end
      n_cmp++; if (dn_wdata !== 32'hDEADBEEF) begin n_fail++; $display("FAIL pw_dn_wdata: got %h want deadbeef", dn_wdata); end
      n_cmp++; if (empty !== 1'b0) begin n_fail++; $display("FAIL pw_busy_empty: got %b want 0", empty); end
      cyc = 0;
      do begin @(negedge clk); cyc++; end while (dn_wr === 1'b1 && cyc < 50);
      n_cmp++; if (cyc != 3) begin n_fail++; $display("FAIL pw_drain_cycles: got %0d want 3", cyc); end
      n_cmp++; if (empty !== 1'b1) begin n_fail++; $display("FAIL pw_empty_after: got %b want 1", empty); end
      n_cmp++; if (n_tx != base + 1) begin n_fail++; $display("FAIL pw_tx_count: got %0d want %0d", n_tx, base + 1); end
   endtask

   task automatic test_full_stall;
      int cyc;
      int base;
      int ups;
      auto_resp = 1'b0; base = n_tx;
      for (int i = 0; i < 4; i++) begin
         do_write(AW'(4 * i), DW'(32'h1000 + 4 * i), cyc);
         n_cmp++; if (cyc != 1) begin n_fail++; $display("FAIL full_wr%0d_latency: got %0d want 1", i, cyc); end
      end
      n_cmp++; if (dn_wr !== 1'b1 || dn_addr !== 32'h0) begin n_fail++; $display("FAIL full_head_drain: got wr=%b addr=%h want wr=1 addr=0", dn_wr, dn_addr); end
      up_addr = 32'h10; up_wdata = 32'h1010; up_wr = 1'b1;
      ups = 0;
      repeat (3) begin @(negedge clk); if (up_ready === 1'b1) ups++; end
      n_cmp++; if (ups != 0) begin n_fail++; $display("FAIL full_stall: got %0d ready pulses want 0", ups); end
      pulse_cnt++;
      cyc = 0;
      do begin @(negedge clk); cyc++; end while (up_ready !== 1'b1 && cyc < 20);
      n_cmp++; if (cyc != 2) begin n_fail++; $display("FAIL full_accept_on_pop: got %0d want 2", cyc); end
      n_cmp++; if (dn_wr !== 1'b0) begin n_fail++; $display("FAIL full_pop_dn_wr: got %b want 0", dn_wr); end
      n_cmp++; if (n_tx != base + 1 || tx_addr[base] !== 32'h0) begin n_fail++; $display("FAIL full_first_drain: got n=%0d addr=%h want n=%0d addr=0", n_tx, tx_addr[base], base + 1); end
      // sixth write must still stall: count stayed at DEPTH after push+pop
      up_addr = 32'h14; up_wdata = 32'h1014;
      ups = 0;
      repeat (3) begin @(negedge clk); if (up_ready === 1'b1) ups++; end
      n_cmp++; if (ups != 0) begin n_fail++; $display("FAIL full_still_full: got %0d ready pulses want 0", ups); end
      n_cmp++; if (dn_wr !== 1'b1 || dn_addr !== 32'h4) begin n_fail++; $display("FAIL full_second_drain: got wr=%b addr=%h want wr=1 addr=4", dn_wr, dn_addr); end
      lat = 1; auto_resp = 1'b1;
      cyc = 0;
      do begin @(negedge clk); cyc++; end while (up_ready !== 1'b1 && cyc < 50);
      up_wr = 1'b0;
      n_cmp++; if (cyc >= 50) begin n_fail++; $display("FAIL full_sixth_accept: got timeout want accept"); end
      wait_empty(cyc);
      n_cmp++; if (n_tx != base + 6) begin n_fail++; $display("FAIL full_tx_count: got %0d want %0d", n_tx, base + 6); end
      for (int i = 1; i < 6; i++) begin
         n_cmp++;
         if (tx_wr[base + i] !== 1'b1 || tx_addr[base + i] !== AW'(4 * i) || tx_data[base + i] !== DW'(32'h1000 + 4 * i)) begin
            n_fail++;
            $display("FAIL full_order%0d: got wr=%b addr=%h data=%h want wr=1 addr=%h data=%h", i,
                     tx_wr[base + i], tx_addr[base + i], tx_data[base + i], AW'(4 * i), DW'(32'h1000 + 4 * i));
         end
      end
   endtask

   task automatic test_forwarding;
      int cyc;
      int base;
      logic [DW-1:0] d;
      base = n_tx;
`ifdef WBUF_FWD_EN
      auto_resp = 1'b0;
      do_write(32'h20, 32'h11, cyc);
      do_write(32'h20, 32'h22, cyc);
      do_read(32'h20, d, cyc);
      n_cmp++; if (cyc != 1) begin n_fail++; $display("FAIL fwd_latency: got %0d want 1", cyc); end
      n_cmp++; if (d !== 32'h22) begin n_fail++; $display("FAIL fwd_data: got %h want 00000022", d); end
      n_cmp++; if (dn_rd !== 1'b0 || n_tx != base) begin n_fail++; $display("FAIL fwd_no_mem: got dn_rd=%b tx=%0d want 0 and %0d", dn_rd, n_tx, base); end
      auto_resp = 1'b1; lat = 1;
      wait_empty(cyc);
      n_cmp++; if (n_tx != base + 2) begin n_fail++; $display("FAIL fwd_tx_count: got %0d want %0d", n_tx, base + 2); end
      n_cmp++;
      if (tx_wr[base] !== 1'b1 || tx_data[base] !== 32'h11 || tx_wr[base + 1] !== 1'b1 || tx_data[base + 1] !== 32'h22) begin
         n_fail++;
         $display("FAIL fwd_drain_order: got %h,%h want 00000011,00000022", tx_data[base], tx_data[base + 1]);
      end
`else
      auto_resp = 1'b1; lat = 2; rd_value = 32'h22;
      do_write(32'h20, 32'h11, cyc);
      do_write(32'h20, 32'h22, cyc);
      do_read(32'h20, d, cyc);
      n_cmp++; if (d !== 32'h22) begin n_fail++; $display("FAIL nofwd_data: got %h want 00000022", d); end
      n_cmp++; if (cyc <= 1) begin n_fail++; $display("FAIL nofwd_read_waits: got %0d cycles want >1", cyc); end
      n_cmp++; if (n_tx != base + 3) begin n_fail++; $display("FAIL nofwd_tx_count: got %0d want %0d", n_tx, base + 3); end
      n_cmp++;
      if (tx_wr[base] !== 1'b1 || tx_data[base] !== 32'h11 || tx_wr[base + 1] !== 1'b1 || tx_data[base + 1] !== 32'h22 ||
          tx_wr[base + 2] !== 1'b0 || tx_addr[base + 2] !== 32'h20) begin
         n_fail++;
         $display("FAIL nofwd_order: got wr=%b%b%b last_addr=%h want wr=110 last_addr=00000020",
                  tx_wr[base], tx_wr[base + 1], tx_wr[base + 2], tx_addr[base + 2]);
      end
`endif
   endtask

   task automatic test_read_bypass;
      int cyc;
      int base;
      auto_resp = 1'b0; rd_value = 32'h55; base = n_tx;
      do_write(32'h3C, 32'h33, cyc);
      do_write(32'h40, 32'hAA, cyc);
      up_addr = 32'h80; up_rd = 1'b1;
      repeat (2) @(negedge clk);
      n_cmp++; if (dn_wr !== 1'b1 || dn_addr !== 32'h3C || up_ready !== 1'b0) begin n_fail++; $display("FAIL byp_drain_first: got wr=%b addr=%h rdy=%b want wr=1 addr=3c rdy=0", dn_wr, dn_addr, up_ready); end
      pulse_cnt++;
      repeat (3) @(negedge clk);
`ifdef WBUF_FWD_EN
      n_cmp++; if (dn_rd !== 1'b1 || dn_wr !== 1'b0 || dn_addr !== 32'h80) begin n_fail++; $display("FAIL byp_read_priority: got rd=%b wr=%b addr=%h want rd=1 wr=0 addr=80", dn_rd, dn_wr, dn_addr); end
`else
      n_cmp++; if (dn_wr !== 1'b1 || dn_rd !== 1'b0 || dn_addr !== 32'h40) begin n_fail++; $display("FAIL byp_drain_before_read: got rd=%b wr=%b addr=%h want rd=0 wr=1 addr=40", dn_rd, dn_wr, dn_addr); end
`endif
      auto_resp = 1'b1; lat = 2;
      cyc = 0;
      while (up_ready !== 1'b1 && cyc < 50) begin @(negedge clk); cyc++; end
      n_cmp++; if (up_rdata !== 32'h55) begin n_fail++; $display("FAIL byp_rdata: got %h want 00000055", up_rdata); end
      up_rd = 1'b0;
      @(negedge clk);
      wait_empty(cyc);
      n_cmp++; if (n_tx != base + 3) begin n_fail++; $display("FAIL byp_tx_count: got %0d want %0d", n_tx, base + 3); end
`ifdef WBUF_FWD_EN
      n_cmp++;
      if (tx_addr[base] !== 32'h3C || tx_wr[base + 1] !== 1'b0 || tx_addr[base + 1] !== 32'h80 ||
          tx_wr[base + 2] !== 1'b1 || tx_addr[base + 2] !== 32'h40 || tx_data[base + 2] !== 32'hAA) begin
         n_fail++;
         $display("FAIL byp_order: got %h,%h,%h want 3c,80(rd),40", tx_addr[base], tx_addr[base + 1], tx_addr[base + 2]);
      end
`else
      n_cmp++;
      if (tx_addr[base] !== 32'h3C || tx_wr[base + 1] !== 1'b1 || tx_addr[base + 1] !== 32'h40 ||
          tx_wr[base + 2] !== 1'b0 || tx_addr[base + 2] !== 32'h80) begin
         n_fail++;
         $display("FAIL byp_order: got %h,%h,%h want 3c,40,80(rd)", tx_addr[base], tx_addr[base + 1], tx_addr[base + 2]);
      end
`endif
   endtask

   initial begin
      rst_n    = 1'b0;
      up_addr  = '0;
      up_rd    = 1'b0;
      up_wr    = 1'b0;
      up_wdata = '0;
      test_reset();
      test_posted_write();
      test_full_stall();
      test_forwarding();
      test_read_bypass();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
